// File: rtl/axis_video_ctrl.sv
// AXI4-Stream video sequencer: SOF-synchronised framing, 2-entry skid buffer, RGB444->RGB888.
// Define AXIS_VIDEO_CTRL_STATS_EN to build the frame and underflow counters.
module axis_video_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sof,
  input  logic [11:0]      rgb_in,
  input  logic             rgb_valid,
  output logic             rgb_ready,
  output logic [23:0]      tdata,
  output logic             tvalid,
  output logic             tuser,
  output logic             tlast,
  input  logic             tready,
  output logic             busy,
  output logic             sof_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] underflow_cnt
);

  localparam int unsigned COL_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned ROW_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned DATA_W = 24;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM, FLUSH} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              user;
    logic              last;
  } beat_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  beat_t            out_q, skid_q, in_beat;
  logic             out_vld_q, skid_vld_q;
  logic             in_fire, out_fire, col_end, row_end, flush_done;
  logic             mid_sof, stream_entry;

  assign rgb_ready  = (state_q == STREAM) && !skid_vld_q;
  assign in_fire    = rgb_valid && rgb_ready;
  assign out_fire   = out_vld_q && tready;
  assign col_end    = (col_q == COL_W'(H_ACTIVE - 1));
  assign row_end    = (row_q == ROW_W'(V_ACTIVE - 1));
  // The frame's last pixel is the youngest buffered beat, so it leaves once the skid is empty.
  assign flush_done = (state_q == FLUSH) && out_fire && !skid_vld_q;

  assign in_beat = {rgb_in[11:8], rgb_in[11:8], rgb_in[7:4], rgb_in[7:4],
                    rgb_in[3:0], rgb_in[3:0],
                    (col_q == '0) && (row_q == '0), col_end};

  assign tdata  = out_q.data;
  assign tuser  = out_q.user;
  assign tlast  = out_q.last;
  assign tvalid = out_vld_q;
  assign busy   = (state_q != IDLE);

  // State register
  always_ff @(posedge pixel_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; a sof coinciding with the flush handshake is a clean frame start
  always_comb begin
    state_d      = state_q;
    mid_sof      = 1'b0;
    stream_entry = 1'b0;
    case (state_q)
      IDLE:     if (enable) state_d = WAIT_SOF;
      WAIT_SOF: if (sof) state_d = STREAM;
      STREAM: begin
        if (sof)                                mid_sof = 1'b1;
        else if (in_fire && col_end && row_end) state_d = FLUSH;
      end
      FLUSH: begin
        if (flush_done) begin
          if (enable) state_d = sof ? STREAM : WAIT_SOF;
          else        state_d = IDLE;
        end else if (sof) begin
          mid_sof = 1'b1;
          state_d = STREAM;
        end
      end
      default: state_d = IDLE;
    endcase
    stream_entry = (state_d == STREAM) && ((state_q != STREAM) || mid_sof);
  end

  // Input position counters
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (stream_entry) begin
      col_q <= '0;
      row_q <= '0;
    end else if (in_fire) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Output + skid register; a pixel presented alongside a mid-frame sof is dropped with the rest
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (mid_sof) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (out_fire || !out_vld_q) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else if (in_fire) begin
        out_q     <= in_beat;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q     <= in_beat;
      skid_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset)        sof_err <= 1'b0;
    else if (mid_sof) sof_err <= 1'b1;
  end

`ifdef AXIS_VIDEO_CTRL_STATS_EN
  logic first_q;

  always_ff @(posedge pixel_clk) begin
    if (reset) first_q <= 1'b0;
    else       first_q <= stream_entry;
  end

  // Saturating status counters
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      frame_cnt     <= '0;
      underflow_cnt <= '0;
    end else begin
      if (flush_done && (frame_cnt != '1))
        frame_cnt <= frame_cnt + CNT_W'(1);
      if ((state_q == STREAM) && !first_q && tready && !out_vld_q && (underflow_cnt != '1))
        underflow_cnt <= underflow_cnt + CNT_W'(1);
    end
  end
`else
  assign frame_cnt     = '0;
  assign underflow_cnt = '0;
`endif

endmodule
